// File: rtl/adc_phs_pkg.sv
// Shared field positions, status layout and sequencer state encoding
// for the ADC IODELAY tap-step controller.
package adc_phs_pkg;

  localparam int TOG_BIT = 31;
  localparam int CLR_BIT = 30;
  localparam int LANE_LO = 8;
  localparam int LANE_HI = 11;
  localparam int LANE_W  = 4;

  localparam int ST_BUSY     = 31;
  localparam int ST_LANE_ERR = 30;
  localparam int ST_OVERRUN  = 29;
  localparam int ST_ACK      = 28;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    STEP,
    SETTLE,
    DONE
  } state_e;

  function automatic logic lane_valid(input logic [LANE_W-1:0] lane, input int n_lanes);
    return int'(lane) < n_lanes;
  endfunction

endpackage

// File: rtl/adc_phs_step_ctrl_if.sv
// Command/status and IODELAY control bundle between software register
// logic (master) and the tap-step sequencer (slave).
interface adc_phs_step_ctrl_if #(
  parameter int N_LANES = 8
);
  logic [31:0]        cmd_word;
  logic [N_LANES-1:0] dly_ce;
  logic               dly_inc;
  logic               busy;
  logic               done;
  logic [31:0]        status_word;

  modport master (output cmd_word, input dly_ce, dly_inc, busy, done, status_word);
  modport slave  (input cmd_word, output dly_ce, dly_inc, busy, done, status_word);
endinterface

// File: rtl/adc_phs_tap_table.sv
// Per-lane current IODELAY tap register file: one read port, one +/-1
// update port, cleared by reset alongside the IODELAYs.
module adc_phs_tap_table
  import adc_phs_pkg::*;
#(
  parameter int N_LANES = 8,
  parameter int TAP_W   = 5
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [LANE_W-1:0] rd_lane,
  output logic [TAP_W-1:0]  rd_tap,
  input  logic              wr_en,
  input  logic [LANE_W-1:0] wr_lane,
  input  logic              wr_up
);

  logic [N_LANES-1:0][TAP_W-1:0] tap_all;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    logic [TAP_W-1:0] tap_q, tap_d;

    always_comb begin
      tap_d = tap_q;
      if (wr_en && (wr_lane == LANE_W'(gi))) begin
        tap_d = wr_up ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
      end
    end

    always_ff @(posedge clk) begin
      if (srst) tap_q <= '0;
      else      tap_q <= tap_d;
    end

    assign tap_all[gi] = tap_q;
  end

  always_comb begin
    rd_tap = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (rd_lane == LANE_W'(i)) rd_tap = tap_all[i];
    end
  end

endmodule

// File: rtl/adc_phs_step_ctrl.sv
// Turns a toggle-qualified absolute tap command into single IODELAY steps
// with a settle gap, tracking every lane's tap and reporting status.
module adc_phs_step_ctrl
  import adc_phs_pkg::*;
#(
  parameter int N_LANES    = 8,
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 16
) (
  input logic                  user_clk,
  input logic                  user_rst,
  adc_phs_step_ctrl_if.slave   bus
);

  state_e             state_q, state_d;
  logic               cmd_tog_q, cmd_tog_d, cmd_clr_q, cmd_clr_d;
  logic [LANE_W-1:0]  cmd_lane_q, cmd_lane_d;
  logic [TAP_W-1:0]   cmd_tgt_q, cmd_tgt_d;
  logic               pend_vld_q, pend_vld_d, pend_tog_q, pend_tog_d, pend_clr_q, pend_clr_d;
  logic [LANE_W-1:0]  pend_lane_q, pend_lane_d;
  logic [TAP_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic               tog_seen_q, tog_seen_d, tog_last_q, tog_last_d, ack_q, ack_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [TAP_W-1:0]   target_q, target_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               lane_err_q, lane_err_d, overrun_q, overrun_d;
  logic [N_LANES-1:0] dly_ce_q, dly_ce_d, lane_onehot;
  logic               dly_inc_q, dly_inc_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]        status_q, status_d;

  logic               req, take, sel_tog, sel_clr, sel_ok, wr_en, wr_up;
  logic [LANE_W-1:0]  sel_lane;
  logic [TAP_W-1:0]   sel_tgt, rd_tap;
  logic               unused_cmd;

  assign unused_cmd = ^bus.cmd_word;

  adc_phs_tap_table #(.N_LANES(N_LANES), .TAP_W(TAP_W)) u_tap_table (
    .clk     (user_clk),
    .srst    (user_rst),
    .rd_lane (lane_q),
    .rd_tap  (rd_tap),
    .wr_en   (wr_en),
    .wr_lane (lane_q),
    .wr_up   (wr_up)
  );

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_onehot
    assign lane_onehot[gi] = (lane_q == LANE_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    cmd_tog_d   = bus.cmd_word[TOG_BIT];
    cmd_clr_d   = bus.cmd_word[CLR_BIT];
    cmd_lane_d  = bus.cmd_word[LANE_HI:LANE_LO];
    cmd_tgt_d   = bus.cmd_word[TAP_W-1:0];
    pend_vld_d  = pend_vld_q;
    pend_tog_d  = pend_tog_q;
    pend_clr_d  = pend_clr_q;
    pend_lane_d = pend_lane_q;
    pend_tgt_d  = pend_tgt_q;
    tog_seen_d  = tog_seen_q;
    tog_last_d  = tog_last_q;
    ack_d       = ack_q;
    lane_d      = lane_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    lane_err_d  = lane_err_q;
    overrun_d   = overrun_q;
    wr_en       = 1'b0;
    wr_up       = 1'b0;
    take        = 1'b0;
    sel_tog     = cmd_tog_q;
    sel_clr     = cmd_clr_q;
    sel_lane    = cmd_lane_q;
    sel_tgt     = cmd_tgt_q;

    // Toggle edges are tracked separately from the executing command so
    // the ack only moves once that command has actually finished.
    req = (cmd_tog_q != tog_seen_q);
    if (req) tog_seen_d = cmd_tog_q;

    if (state_q == IDLE) begin
      if (pend_vld_q) begin
        take       = 1'b1;
        sel_tog    = pend_tog_q;
        sel_clr    = pend_clr_q;
        sel_lane   = pend_lane_q;
        sel_tgt    = pend_tgt_q;
        pend_vld_d = 1'b0;
      end else if (req) begin
        take = 1'b1;
      end
    end

    // A request that cannot be taken now waits in the single pending slot.
    if (req && (state_q != IDLE || pend_vld_q)) begin
      if (state_q != IDLE && pend_vld_q) overrun_d = 1'b1;
      pend_vld_d  = 1'b1;
      pend_tog_d  = cmd_tog_q;
      pend_clr_d  = cmd_clr_q;
      pend_lane_d = cmd_lane_q;
      pend_tgt_d  = cmd_tgt_q;
    end

    sel_ok = lane_valid(sel_lane, N_LANES);
    if (take) begin
      tog_last_d = sel_tog;
      if (sel_clr) begin
        lane_err_d = 1'b0;
        overrun_d  = 1'b0;
      end
      if (!sel_ok) begin
        lane_err_d = 1'b1;
        ack_d      = sel_tog;
      end else begin
        lane_d   = sel_lane;
        target_d = sel_tgt;
        state_d  = CMP;
      end
    end

    case (state_q)
      CMP:    state_d = (rd_tap == target_q) ? DONE : STEP;
      STEP: begin
        wr_en   = 1'b1;
        wr_up   = (target_q > rd_tap);
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 8'(SETTLE_CYC - 1)) state_d = CMP;
        else                             cnt_d   = cnt_q + 8'd1;
      end
      DONE: begin
        ack_d   = tog_last_q;
        state_d = IDLE;
      end
      default: ;
    endcase

    // Outputs are registered from the next state so the CE pulse is glitch-free.
    dly_ce_d  = (state_d == STEP) ? lane_onehot : '0;
    dly_inc_d = (state_d == STEP) && (target_q > rd_tap);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE) || (take && !sel_ok);

    status_d                  = '0;
    status_d[ST_BUSY]         = busy_q;
    status_d[ST_LANE_ERR]     = lane_err_q;
    status_d[ST_OVERRUN]      = overrun_q;
    status_d[ST_ACK]          = ack_q;
    status_d[LANE_HI:LANE_LO] = lane_q;
    status_d[TAP_W-1:0]       = rd_tap;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q     <= IDLE;
      cmd_tog_q   <= 1'b0;
      cmd_clr_q   <= 1'b0;
      cmd_lane_q  <= '0;
      cmd_tgt_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_tog_q  <= 1'b0;
      pend_clr_q  <= 1'b0;
      pend_lane_q <= '0;
      pend_tgt_q  <= '0;
      tog_seen_q  <= 1'b0;
      tog_last_q  <= 1'b0;
      ack_q       <= 1'b0;
      lane_q      <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      lane_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      dly_ce_q    <= '0;
      dly_inc_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_tog_q   <= cmd_tog_d;
      cmd_clr_q   <= cmd_clr_d;
      cmd_lane_q  <= cmd_lane_d;
      cmd_tgt_q   <= cmd_tgt_d;
      pend_vld_q  <= pend_vld_d;
      pend_tog_q  <= pend_tog_d;
      pend_clr_q  <= pend_clr_d;
      pend_lane_q <= pend_lane_d;
      pend_tgt_q  <= pend_tgt_d;
      tog_seen_q  <= tog_seen_d;
      tog_last_q  <= tog_last_d;
      ack_q       <= ack_d;
      lane_q      <= lane_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      lane_err_q  <= lane_err_d;
      overrun_q   <= overrun_d;
      dly_ce_q    <= dly_ce_d;
      dly_inc_q   <= dly_inc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
    end
  end

  assign bus.dly_ce      = dly_ce_q;
  assign bus.dly_inc     = dly_inc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.status_word = status_q;

endmodule
